tempo_io_frontend: RTL and testbench

Input/output front end for the drum-machine tempo path. It converts the held tempo-key level into a one-cycle press pulse for the BPM counter. It also converts the 14-bit binary tempo into packed BCD and drives four active-low seven-segment displays. It sits between the key/hold logic, the BPM counter and the board HEX outputs.

---
 rtl/tempo_io_frontend_pkg.sv | 40 ++++
 rtl/tempo_io_frontend_if.sv | 34 +++
 rtl/tempo_io_frontend_seven_segment.sv | 19 +
 rtl/tempo_io_frontend.sv | 103 ++++++++++
 tb/tb_tempo_io_frontend.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tempo_io_frontend_pkg.sv
// Shared types and constants for the tempo I/O front end: segment
// encodings, the largest displayable tempo and the BCD digit type.
package tempo_pkg;

    // Every segment dark, in active-low form.
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Largest tempo that fits on four decimal digits; above this the
    // display saturates at 9999 and raises ovf.
    localparam logic [13:0] BCD_MAX = 14'd9999;

    // Saturated display value used when the tempo is out of range.
    localparam logic [15:0] BCD_SAT = 16'h9999;

    // One packed BCD digit.
    typedef logic [3:0] bcd_digit_t;

    // Active-low segment patterns, bit0 = a ... bit6 = g.
    // Codes A..F never come out of the BCD path but stay decodable so the
    // decoder can be reused for hex displays.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage

// File: rtl/tempo_io_frontend_if.sv
// Bundle of the tempo front-end signals shared between the key/hold
// logic, the BPM counter and the board displays.
//
// Signalling: there is no valid/ready handshake on this bundle. in, tempo
// and enable are levels sampled on every rising clock edge; press is a
// registered single-cycle strobe and bcd/ovf/HEXn are registered levels
// that always describe the tempo sampled on the previous edge.
interface tempo_io_frontend_if;
    import tempo_pkg::*;

    logic        in;
    logic [13:0] tempo;
    logic        enable;
    logic        press;
    logic [15:0] bcd;
    logic        ovf;
    logic [6:0]  HEX0;
    logic [6:0]  HEX1;
    logic [6:0]  HEX2;
    logic [6:0]  HEX3;

    // Side that drives the key level and tempo, and consumes the results.
    modport master (
        output in, tempo, enable,
        input  press, bcd, ovf, HEX0, HEX1, HEX2, HEX3
    );

    // The front end itself.
    modport slave (
        input  in, tempo, enable,
        output press, bcd, ovf, HEX0, HEX1, HEX2, HEX3
    );

endinterface

// File: rtl/tempo_io_frontend_seven_segment.sv
// Combinational seven-segment decoder for one digit, active-low output.
// A disabled digit is driven fully dark.
module seven_segment
    import tempo_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       enable,
    output logic [6:0] seg
);

    // Table lookup, forced dark when the digit is not shown.
    always_comb begin
        seg = SEG_OFF;
        if (enable) begin
            seg = SEG_LUT[digit];
        end
    end

endmodule

// File: rtl/tempo_io_frontend.sv
// Tempo I/O front end: turns the held key level into a single press
// strobe and turns the binary tempo into packed BCD plus four
// seven-segment patterns, all registered with one cycle of latency.
module tempo_io_frontend
    import tempo_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit LEADING_BLANK  = 1'b0
) (
    input logic                 clock,
    input logic                 reset,
    tempo_io_frontend_if.slave  bus
);

    // Pattern that leaves a digit dark in the configured polarity.
    localparam logic [6:0] HEX_OFF = SEG_ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;

    // Key history; resets high so a key held through reset is ignored
    // until it has been released once.
    logic prev;

    // Double-dabble scratch: 16 BCD bits above the 14 binary bits.
    logic [29:0] dd_shift;
    logic [15:0] bcd_next;
    logic        ovf_next;

    bcd_digit_t  dig [4];
    logic [3:1]  lead_zero;
    logic [3:0]  dig_en;
    logic [6:0]  seg_raw [4];
    logic [6:0]  seg_next [4];

    // Rising-edge detect on the key level, registered press strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev      <= 1'b1;
            bus.press <= 1'b0;
        end else begin
            prev      <= bus.in;
            bus.press <= bus.in & ~prev;
        end
    end

    // Binary to BCD by shift-and-add-3, saturating above four digits.
    // Out-of-range tempos overflow the scratch but are replaced by 9999.
    always_comb begin
        dd_shift = {16'd0, bus.tempo};
        for (int i = 0; i < 14; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (dd_shift[14 + 4*d +: 4] >= 4'd5) begin
                    dd_shift[14 + 4*d +: 4] = dd_shift[14 + 4*d +: 4] + 4'd3;
                end
            end
            dd_shift = dd_shift << 1;
        end
        ovf_next = (bus.tempo > BCD_MAX);
        bcd_next = ovf_next ? BCD_SAT : dd_shift[29:14];
    end

    // Split into digits and decide which ones are lit.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            dig[n] = bcd_next[4*n +: 4];
        end
        lead_zero[3] = (dig[3] == 4'd0);
        lead_zero[2] = lead_zero[3] && (dig[2] == 4'd0);
        lead_zero[1] = lead_zero[2] && (dig[1] == 4'd0);
        dig_en[0]    = bus.enable;
        for (int n = 1; n < 4; n++) begin
            dig_en[n] = bus.enable && !(LEADING_BLANK && lead_zero[n]);
        end
    end

    // One decoder per display; polarity applied after decoding.
    for (genvar g = 0; g < 4; g++) begin : g_seg
        seven_segment u_seg (
            .digit  (dig[g]),
            .enable (dig_en[g]),
            .seg    (seg_raw[g])
        );
        assign seg_next[g] = SEG_ACTIVE_LOW ? seg_raw[g] : ~seg_raw[g];
    end

    // Display registers: bcd, ovf and HEXn capture the same tempo sample.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.bcd  <= 16'h0000;
            bus.ovf  <= 1'b0;
            bus.HEX0 <= HEX_OFF;
            bus.HEX1 <= HEX_OFF;
            bus.HEX2 <= HEX_OFF;
            bus.HEX3 <= HEX_OFF;
        end else begin
            bus.bcd  <= bcd_next;
            bus.ovf  <= ovf_next;
            bus.HEX0 <= seg_next[0];
            bus.HEX1 <= seg_next[1];
            bus.HEX2 <= seg_next[2];
            bus.HEX3 <= seg_next[3];
        end
    end

endmodule

// File: tb/tb_tempo_io_frontend.sv
// Bench for tempo_io_frontend: one instance with default parameters and
// one with leading-zero blanking, both driven with the same stimulus.
module tb_tempo_io_frontend;

    localparam int W = 73;  // {ovf, bcd, hex_a[27:0], hex_b[27:0]}

    logic clock;
    logic reset;

    tempo_io_frontend_if bus_a ();
    tempo_io_frontend_if bus_b ();

    tempo_io_frontend dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    tempo_io_frontend #(.SEG_ACTIVE_LOW(1'b1), .LEADING_BLANK(1'b1)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic         press_q[$];
    logic         prev_m;
    int           vectors;
    int           miscompares;

    logic [W-1:0] exp_v;
    logic         exp_p;
    logic [44:0]  got_a;
    logic [27:0]  got_b;

    assign got_a = {bus_a.ovf, bus_a.bcd, bus_a.HEX3, bus_a.HEX2, bus_a.HEX1, bus_a.HEX0};
    assign got_b = {bus_b.HEX3, bus_b.HEX2, bus_b.HEX1, bus_b.HEX0};

    // ---------------- reference model ----------------
    function automatic logic [6:0] seg_tab(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [W-1:0] model(input int t, input logic en);
        int          v;
        int          pw;
        logic [3:0]  dg;
        logic [15:0] b;
        logic [27:0] ha;
        logic [27:0] hb;
        logic        ov;
        ov = (t > 9999);
        v  = ov ? 9999 : t;
        pw = 1;
        b  = '0;
        ha = '0;
        hb = '0;
        for (int n = 0; n < 4; n++) begin
            dg = 4'((v / pw) % 10);
            b[4*n +: 4]  = dg;
            ha[7*n +: 7] = en ? seg_tab(int'(dg)) : 7'h7F;
            hb[7*n +: 7] = (en && (n == 0 || v >= pw)) ? seg_tab(int'(dg)) : 7'h7F;
            pw = pw * 10;
        end
        return {ov, b, ha, hb};
    endfunction

    // ---------------- driver ----------------
    // Drives one cycle of stimulus on both instances, records expectations,
    // and returns just after the capturing clock edge.
    task automatic drive(input logic in_v, input int t, input logic en_v);
        @(negedge clock);
        bus_a.in     = in_v;
        bus_b.in     = in_v;
        bus_a.tempo  = t[13:0];
        bus_b.tempo  = t[13:0];
        bus_a.enable = en_v;
        bus_b.enable = en_v;
        exp_q.push_back(model(t, en_v));
        press_q.push_back(in_v & ~prev_m);
        prev_m = in_v;
        @(posedge clock);
        #1;
    endtask

    task automatic pop_exp();
        exp_v = exp_q.pop_front();
        exp_p = press_q.pop_front();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        bus_a.in = 1'b1;  bus_b.in = 1'b1;
        bus_a.tempo = 14'd60;  bus_b.tempo = 14'd60;
        bus_a.enable = 1'b1;  bus_b.enable = 1'b1;
        prev_m = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        vectors++;
        if (got_a !== {1'b0, 16'h0000, {4{7'h7F}}}) begin
            miscompares++;
            $display("FAIL reset_display got=%h exp=%h", got_a, {1'b0, 16'h0000, {4{7'h7F}}});
        end
        vectors++;
        if (got_b !== {4{7'h7F}} || bus_a.press !== 1'b0 || bus_b.press !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_misc hex_b=%h press=%b/%b exp hex_b=%h press=0", got_b, bus_a.press, bus_b.press, {4{7'h7F}});
        end
        @(negedge clock);
        reset = 1'b1;
        // Key still held after release, then released and pressed again.
        for (int i = 0; i < 6; i++) begin
            drive((i < 3 || i == 4) ? 1'b1 : 1'b0, 60, 1'b1);
            pop_exp();
            vectors++;
            if (bus_a.press !== exp_p || bus_b.press !== exp_p) begin
                miscompares++;
                $display("FAIL reset_press step=%0d got=%b/%b exp=%b", i, bus_a.press, bus_b.press, exp_p);
            end
        end
    endtask

    task automatic test_display_basic();
        drive(1'b0, 60, 1'b1);
        pop_exp();
        vectors++;
        if (got_a !== {1'b0, 16'h0060, 7'b1000000, 7'b1000000, 7'b0000010, 7'b1000000}) begin
            miscompares++;
            $display("FAIL tempo60 got=%h exp=%h", got_a, {1'b0, 16'h0060, 7'b1000000, 7'b1000000, 7'b0000010, 7'b1000000});
        end
        vectors++;
        if (got_b !== exp_v[27:0]) begin
            miscompares++;
            $display("FAIL tempo60_blank got=%h exp=%h", got_b, exp_v[27:0]);
        end
    endtask

    task automatic test_sweep();
        for (int t = 0; t <= 9999; t++) begin
            drive(1'b0, t, 1'b1);
            pop_exp();
            vectors++;
            if (got_a !== exp_v[72:28] || got_b !== exp_v[27:0]) begin
                miscompares++;
                $display("FAIL sweep t=%0d got=%h/%h exp=%h", t, got_a, got_b, exp_v);
            end
            if (t == 1234) begin
                vectors++;
                if (bus_a.bcd !== 16'h1234 || bus_a.HEX3 !== 7'b1111001) begin
                    miscompares++;
                    $display("FAIL spot1234 bcd=%h hex3=%b exp bcd=1234 hex3=1111001", bus_a.bcd, bus_a.HEX3);
                end
            end
            if (t == 9999) begin
                vectors++;
                if (got_a !== {1'b0, 16'h9999, {4{7'b0010000}}}) begin
                    miscompares++;
                    $display("FAIL spot9999 got=%h exp=%h", got_a, {1'b0, 16'h9999, {4{7'b0010000}}});
                end
            end
        end
    endtask

    task automatic test_overflow();
        drive(1'b0, 16383, 1'b1);
        pop_exp();
        vectors++;
        if (bus_a.bcd !== 16'h9999 || bus_a.ovf !== 1'b1 || got_b !== exp_v[27:0]) begin
            miscompares++;
            $display("FAIL ovf_max bcd=%h ovf=%b hex_b=%h exp bcd=9999 ovf=1 hex_b=%h", bus_a.bcd, bus_a.ovf, got_b, exp_v[27:0]);
        end
        drive(1'b0, 10000, 1'b1);
        pop_exp();
        vectors++;
        if (got_a !== exp_v[72:28]) begin
            miscompares++;
            $display("FAIL ovf_10000 got=%h exp=%h", got_a, exp_v[72:28]);
        end
        drive(1'b0, 5, 1'b1);
        pop_exp();
        vectors++;
        if (bus_a.bcd !== 16'h0005 || bus_a.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear bcd=%h ovf=%b exp bcd=0005 ovf=0", bus_a.bcd, bus_a.ovf);
        end
    endtask

    task automatic test_press_pattern();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            drive((i >= 1 && i <= 20) || i == 24, 60 + i, 1'b1);
            pop_exp();
            if (bus_a.press === 1'b1) pulses++;
            vectors++;
            if (bus_a.press !== exp_p || bus_b.press !== exp_p || got_a !== exp_v[72:28]) begin
                miscompares++;
                $display("FAIL press_pattern step=%0d press=%b/%b exp=%b disp=%h exp=%h", i, bus_a.press, bus_b.press, exp_p, got_a, exp_v[72:28]);
            end
        end
        vectors++;
        if (pulses != 2) begin
            miscompares++;
            $display("FAIL press_count got=%0d exp=2", pulses);
        end
    endtask

    task automatic test_enable();
        drive(1'b0, 120, 1'b0);
        pop_exp();
        vectors++;
        if (got_a !== {1'b0, 16'h0120, {4{7'h7F}}} || got_b !== {4{7'h7F}}) begin
            miscompares++;
            $display("FAIL enable_off got=%h/%h exp=%h", got_a, got_b, {1'b0, 16'h0120, {4{7'h7F}}});
        end
        drive(1'b0, 120, 1'b1);
        pop_exp();
        vectors++;
        if (got_a !== exp_v[72:28] || got_b !== exp_v[27:0]) begin
            miscompares++;
            $display("FAIL enable_on got=%h/%h exp=%h", got_a, got_b, exp_v);
        end
    endtask

    task automatic test_leading_blank();
        int vals[8];
        vals = '{7, 0, 10, 99, 100, 1000, 1005, 12000};
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, vals[i], 1'b1);
            pop_exp();
            vectors++;
            if (got_b !== exp_v[27:0] || got_a !== exp_v[72:28]) begin
                miscompares++;
                $display("FAIL lead_blank t=%0d got=%h/%h exp=%h", vals[i], got_a, got_b, exp_v);
            end
            if (i == 0) begin
                vectors++;
                if (got_b !== {7'h7F, 7'h7F, 7'h7F, 7'b1111000}) begin
                    miscompares++;
                    $display("FAIL lead_blank7 got=%h exp=%h", got_b, {7'h7F, 7'h7F, 7'h7F, 7'b1111000});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 16383)), ($urandom_range(0, 7) != 0));
            pop_exp();
            vectors++;
            if (got_a !== exp_v[72:28] || got_b !== exp_v[27:0] || bus_a.press !== exp_p) begin
                miscompares++;
                $display("FAIL back_to_back i=%0d got=%h/%h press=%b exp=%h press=%b", i, got_a, got_b, bus_a.press, exp_v, exp_p);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        drive(1'b0, 4321, 1'b1);
        pop_exp();
        drive(1'b1, 4321, 1'b1);
        pop_exp();
        vectors++;
        if (bus_a.press !== 1'b1 || bus_a.bcd !== 16'h4321) begin
            miscompares++;
            $display("FAIL midrun_pre press=%b bcd=%h exp press=1 bcd=4321", bus_a.press, bus_a.bcd);
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (got_a !== {1'b0, 16'h0000, {4{7'h7F}}} || got_b !== {4{7'h7F}} || bus_a.press !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_clear got=%h/%h press=%b exp=%h", got_a, got_b, bus_a.press, {1'b0, 16'h0000, {4{7'h7F}}});
        end
        exp_q.delete();
        press_q.delete();
        prev_m = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        drive(1'b1, 4321, 1'b1);
        pop_exp();
        vectors++;
        if (got_a !== exp_v[72:28] || bus_a.press !== exp_p) begin
            miscompares++;
            $display("FAIL midrun_release got=%h press=%b exp=%h press=%b", got_a, bus_a.press, exp_v[72:28], exp_p);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_display_basic();
        test_sweep();
        test_overflow();
        test_press_pattern();
        test_enable();
        test_leading_blank();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
